// File: rtl/axil_sram_responder_pkg.sv
// Shared types, response codes and address-decode helpers for the AXI4-Lite SRAM responder.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t       RESP_OKAY         = 2'b00;
  localparam resp_t       RESP_SLVERR       = 2'b10;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // The 33-bit subtraction exposes the borrow, so addresses below base fail the check.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return !off[32] && (off < span);
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axil_sram_responder_if.sv
// AXI4-Lite signal bundle between a master and the SRAM responder.
interface axil_sram_responder_if;
  import axil_pkg::*;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  resp_t       rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  resp_t       bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_sram_responder_delay_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) stepping every cycle; source of random response delays.
module axil_delay_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/axil_sram_responder.sv
// AXI4-Lite responder over a word-addressed SRAM with a per-request response delay.
// Define AXIL_RANDOM_DELAY_EN to draw delays from an LFSR instead of FIXED_DELAY.
module axil_sram_responder
  import axil_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          FIXED_DELAY = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                  clk,
  input logic                  rst,
  axil_sram_responder_if.slave bus
);

  localparam int          IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

  logic [3:0] rd_delay_s;
  logic [3:0] wr_delay_s;

`ifdef AXIL_RANDOM_DELAY_EN
  logic [7:0] lfsr_s;

  axil_delay_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .seed_i (LFSR_SEED),
    .lfsr_o (lfsr_s)
  );

  assign rd_delay_s = lfsr_s[3:0];
  assign wr_delay_s = lfsr_s[7:4];
`else
  assign rd_delay_s = 4'(FIXED_DELAY);
  assign wr_delay_s = 4'(FIXED_DELAY);
`endif

  logic [31:0] mem_q [MEM_WORDS];

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  resp_t       rresp_q, rresp_d;
  logic        rvalid_q, rvalid_d;

  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_cap_q, aw_cap_d;
  logic        w_cap_q, w_cap_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  resp_t       bresp_q, bresp_d;
  logic        bvalid_q, bvalid_d;

  logic             rd_hit_s, wr_hit_s, commit_s;
  logic [IDX_W-1:0] rd_idx_s, wr_idx_s;

  assign rd_hit_s = addr_in_range(rd_addr_q, BASE_ADDR, SPAN);
  assign wr_hit_s = addr_in_range(awaddr_q, BASE_ADDR, SPAN);
  assign rd_idx_s = IDX_W'(word_offset(rd_addr_q, BASE_ADDR));
  assign wr_idx_s = IDX_W'(word_offset(awaddr_q, BASE_ADDR));

  assign bus.arready = (rd_state_q == R_IDLE);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.awready = (wr_state_q == W_IDLE) && !aw_cap_q;
  assign bus.wready  = (wr_state_q == W_IDLE) && !w_cap_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;

  // Read path: the response register adds one cycle after sampling, so rvalid rises d+2 cycles after AR.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rvalid_d   = rvalid_q;
    case (rd_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          rd_addr_d  = bus.araddr;
          rd_cnt_d   = rd_delay_s;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rdata_d    = rd_hit_s ? mem_q[rd_idx_s] : 32'h0000_0000;
          rresp_d    = rd_hit_s ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rvalid_q && bus.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write path: AW and W are captured independently; the delay starts once both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_cnt_d   = wr_cnt_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;
    commit_s   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (bus.awvalid && !aw_cap_q) begin
          aw_cap_d = 1'b1;
          awaddr_d = bus.awaddr;
        end
        if (bus.wvalid && !w_cap_q) begin
          w_cap_d = 1'b1;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
        end
        if (aw_cap_d && w_cap_d) begin
          wr_cnt_d   = wr_delay_s;
          wr_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          commit_s   = wr_hit_s;
          bresp_d    = wr_hit_s ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bvalid_q && bus.bready) begin
          bvalid_d   = 1'b0;
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          wr_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Control and response registers; memory contents are deliberately outside the reset domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= 32'h0000_0000;
      rd_cnt_q   <= 4'd0;
      rdata_q    <= 32'h0000_0000;
      rresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      wr_state_q <= W_IDLE;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      wr_cnt_q   <= 4'd0;
      bresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      wr_state_q <= wr_state_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_cnt_q   <= wr_cnt_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
    end
  end

  // Byte-masked commit; a same-cycle read sample still sees the old word.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem_q[wr_idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Directed self-checking bench for axil_sram_responder (default FIXED_DELAY = 0 build,
// with a random-delay scenario when AXIL_RANDOM_DELAY_EN is defined).
module tb_axil_sram_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  axil_sram_responder_if bus ();

  axil_sram_responder #(
    .MEM_WORDS   (1024),
    .BASE_ADDR   (32'h8000_0000),
    .FIXED_DELAY (0),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output bit proto_ok,
                         output bit tmo);
    int guard;
    tmo = 1'b0; proto_ok = 1'b1; lat = 0; guard = 0;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    if (guard >= 40) tmo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    while (bus.rvalid !== 1'b1 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    if (lat >= 40) tmo = 1'b1;
    data = bus.rdata; resp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rvalid !== 1'b1 || bus.rdata !== data || bus.rresp !== resp || bus.arready !== 1'b0)
        proto_ok = 1'b0;
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) proto_ok = 1'b0;
  endtask

  // lead > 0: W issued lead cycles before AW; lead < 0: AW first; 0: same cycle.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int hold, output logic [1:0] resp,
                          output bit proto_ok, output bit tmo);
    int guard;
    int n;
    tmo = 1'b0; proto_ok = 1'b1; guard = 0;
    n = (lead < 0) ? -lead : lead;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    if (lead >= 0) bus.wvalid = 1'b1;
    if (lead <= 0) bus.awvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (lead > 0) begin
        bus.wvalid = 1'b0;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b1) proto_ok = 1'b0;
      end else begin
        bus.awvalid = 1'b0;
        if (bus.awready !== 1'b0 || bus.wready !== 1'b1) proto_ok = 1'b0;
      end
      if (bus.bvalid !== 1'b0) proto_ok = 1'b0;
    end
    if (lead > 0) bus.awvalid = 1'b1;
    if (lead < 0) bus.wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0) proto_ok = 1'b0;
    while (bus.bvalid !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    if (guard >= 40) tmo = 1'b1;
    resp = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.bvalid !== 1'b1 || bus.bresp !== resp || bus.awready !== 1'b0 || bus.wready !== 1'b0)
        proto_ok = 1'b0;
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) proto_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready: got %b want 1", bus.arready); end
    n_checks++; if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready: got %b want 1", bus.awready); end
    n_checks++; if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %b want 1", bus.wready); end
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b want 0", bus.bvalid); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_checks++; if (bus.rresp !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b want 00", bus.rresp); end
    n_checks++; if (bus.bresp !== 2'b00) begin n_fail++; $display("FAIL reset_bresp: got %b want 00", bus.bresp); end
  endtask

  task automatic test_full_write_read();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, ok, tmo);
    n_checks++; if (r !== 2'b00 || tmo) begin n_fail++; $display("FAIL full_bresp: got %b tmo %0d want 00", r, tmo); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_write_proto: got 0 want 1"); end
    do_read(32'h8000_0010, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'hDEAD_BEEF || tmo) begin n_fail++; $display("FAIL full_rdata: got %h want deadbeef", d); end
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL full_rresp: got %b want 00", r); end
`ifdef AXIL_RANDOM_DELAY_EN
    n_checks++; if (lat < 2 || lat > 17) begin n_fail++; $display("FAIL full_latency: got %0d want 2..17", lat); end
`else
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL full_latency: got %0d want 2", lat); end
`endif
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, r, ok, tmo);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0, r, ok, tmo);
    n_checks++; if (r !== 2'b00 || tmo) begin n_fail++; $display("FAIL strobe_bresp: got %b want 00", r); end
    do_read(32'h8000_0020, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_rdata: got %h want 11bb33dd", d); end
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 0, r, ok, tmo);
    n_checks++; if (r !== 2'b00 || tmo) begin n_fail++; $display("FAIL zero_strb_bresp: got %b want 00", r); end
    do_read(32'h8000_0020, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL zero_strb_rdata: got %h want 11bb33dd", d); end
  endtask

  task automatic test_ordering();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    int          leads [3] = '{3, 0, -3};
    logic [31:0] vals  [3] = '{32'h0101_0101, 32'h2222_3333, 32'h4567_89AB};
    for (int k = 0; k < 3; k++) begin
      do_write(32'h8000_0030 + 32'(4 * k), vals[k], 4'hF, leads[k], 0, r, ok, tmo);
      n_checks++; if (!ok || tmo) begin n_fail++; $display("FAIL order_proto[%0d]: got ok=%0d tmo=%0d want ok=1 tmo=0", k, ok, tmo); end
      n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL order_bresp[%0d]: got %b want 00", k, r); end
      do_read(32'h8000_0030 + 32'(4 * k), 0, d, r, lat, ok, tmo);
      n_checks++; if (d !== vals[k]) begin n_fail++; $display("FAIL order_rdata[%0d]: got %h want %h", k, d, vals[k]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, r, ok, tmo);
    do_read(32'h7FFF_FFFC, 0, d, r, lat, ok, tmo);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_low_rresp: got %b want 10", r); end
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_low_rdata: got %h want 0", d); end
    do_read(32'h8000_1000, 0, d, r, lat, ok, tmo);
    n_checks++; if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL oor_high_read: got %b/%h want 10/0", r, d); end
    do_write(32'h8000_1000, 32'h1234_5678, 4'hF, 0, 0, r, ok, tmo);
    n_checks++; if (r !== 2'b10 || tmo) begin n_fail++; $display("FAIL oor_bresp: got %b want 10", r); end
    do_read(32'h8000_0000, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'h0BAD_F00D || r !== 2'b00) begin n_fail++; $display("FAIL oor_mem_unchanged: got %h want 0badf00d", d); end
    do_write(32'h8000_0FFF, 32'h7777_8888, 4'hF, 0, 0, r, ok, tmo);
    do_read(32'h8000_0FFC, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'h7777_8888 || r !== 2'b00) begin n_fail++; $display("FAIL last_word: got %h/%b want 77778888/00", d, r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    do_write(32'h8000_0050, 32'h5A5A_A5A5, 4'hF, 0, 5, r, ok, tmo);
    n_checks++; if (!ok || tmo || r !== 2'b00) begin n_fail++; $display("FAIL bp_write: got ok=%0d bresp=%b want ok=1 bresp=00", ok, r); end
    do_read(32'h8000_0050, 5, d, r, lat, ok, tmo);
    n_checks++; if (!ok || tmo) begin n_fail++; $display("FAIL bp_read_stable: got ok=%0d tmo=%0d want 1/0", ok, tmo); end
    n_checks++; if (d !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL bp_rdata: got %h want 5a5aa5a5", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    do_write(32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, r, ok, tmo);
    @(negedge clk);
    bus.araddr = 32'h8000_0040; bus.arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_checks++; if (bus.arready !== 1'b0) begin n_fail++; $display("FAIL midrd_in_wait: got arready %b want 0", bus.arready); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrd_rvalid[%0d]: got %b want 0", i, bus.rvalid); end
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrd_after: got arready %b rvalid %b want 1/0", bus.arready, bus.rvalid); end
    do_read(32'h8000_0040, 0, d, r, lat, ok, tmo);
    n_checks++; if (d !== 32'hCAFE_F00D || tmo) begin n_fail++; $display("FAIL midrd_mem_kept: got %h want cafef00d", d); end
  endtask

  task automatic test_back_to_back_delays();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit tmo;
    int bad;
    bad = 0;
`ifdef AXIL_RANDOM_DELAY_EN
    for (int i = 0; i < 100; i++) begin
      do_read(32'h8000_0010, 0, d, r, lat, ok, tmo);
      if (lat < 2 || lat > 17 || tmo || d !== 32'hDEAD_BEEF) bad++;
    end
`else
    for (int i = 0; i < 10; i++) begin
      do_read(32'h8000_0010, 0, d, r, lat, ok, tmo);
      if (lat != 2 || tmo || d !== 32'hDEAD_BEEF) bad++;
    end
`endif
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL delay_range: got %0d bad reads want 0", bad); end
  endtask

  initial begin
    bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0;
    bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_write_read();
    test_partial_strobe();
    test_ordering();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back_delays();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
